// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - op encodings, FSM states and store lane helpers
package mem_access_unit_pkg;

  localparam logic [31:0] DATA_LIMIT_DEFAULT = 32'h0000_3000;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } mau_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10,
    ST_ERR    = 2'b11
  } mau_state_e;

  function automatic logic op_is_store(input mau_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic op_misaligned(input mau_op_e op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = lo[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] op_lane_mask(input mau_op_e op, input logic [1:0] lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (op)
      OP_SW:   mask = 4'b1111;
      OP_SH:   mask = lo[1] ? 4'b1100 : 4'b0011;
      OP_SB:   mask = 4'b0001 << lo;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Sub-word stores replicate the source so every lane carries it; byteen picks the live one.
  function automatic logic [31:0] op_store_data(input mau_op_e op, input logic [31:0] wdata);
    logic [31:0] data;
    data = wdata;
    case (op)
      OP_SH:   data = {2{wdata[15:0]}};
      OP_SB:   data = {4{wdata[7:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data bus between the access unit and its memory responder
interface mem_access_unit_if;

  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic        m_data_rd;
  logic [31:0] m_inst_addr;
  logic        m_data_ack;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    output m_data_rd,
    output m_inst_addr,
    input  m_data_ack,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    input  m_data_rd,
    input  m_inst_addr,
    output m_data_ack,
    output m_data_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - lane select and sign/zero extension of a load word
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  mau_op_e     op,
  output logic [31:0] result
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Stores fall through to zero so the top can pass this straight into rdata.
  always_comb begin
    half_sel = addr[1] ? word[31:16] : word[15:0];
    byte_sel = word[{addr, 3'b000} +: 8];
    result   = '0;
    case (op)
      OP_LW:   result = word;
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0000, half_sel};
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h00_0000, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - M-stage load/store unit: alignment check, bus access, ack timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter logic [31:0] DATA_LIMIT  = DATA_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic              bus_err,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mau_state_e       state_q, state_d;
  mau_op_e          req_op_e, op_q;
  logic             req_bad;
  logic             ack_expired;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       lo_q;
  logic [31:0]      addr_q, wdata_q, pc_q, rdata_q;
  logic [31:0]      load_word;
  logic [3:0]       byteen_q;
  logic             rd_q, addr_err_q, bus_err_q;

  assign req_op_e    = mau_op_e'(req_op);
  assign req_bad     = op_misaligned(req_op_e, req_addr[1:0]) || (req_addr >= DATA_LIMIT);
  assign ack_expired = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = req_bad ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.m_data_ack) begin
          state_d = ST_RESP;
        end else if (ack_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result flags and rdata are one-cycle values: they default to zero every cycle
  // and are only set on the edge that enters RESP/ERR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_LW;
      lo_q       <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      pc_q       <= '0;
      byteen_q   <= '0;
      rd_q       <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              addr_err_q <= 1'b1;
            end else begin
              op_q     <= req_op_e;
              lo_q     <= req_addr[1:0];
              addr_q   <= {req_addr[31:2], 2'b00};
              wdata_q  <= op_store_data(req_op_e, req_wdata);
              pc_q     <= req_pc;
              byteen_q <= op_lane_mask(req_op_e, req_addr[1:0]);
              rd_q     <= !op_is_store(req_op_e);
              cnt_q    <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (bus.m_data_ack || ack_expired) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            byteen_q <= '0;
            rd_q     <= 1'b0;
            cnt_q    <= '0;
            if (bus.m_data_ack) begin
              rdata_q <= load_word;
            end else begin
              bus_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  load_extend u_load_extend (
    .word   (bus.m_data_rdata),
    .addr   (lo_q),
    .op     (op_q),
    .result (load_word)
  );

  assign done     = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign busy     = req_valid & ~done;
  assign rdata    = rdata_q;
  assign addr_err = addr_err_q;
  assign bus_err  = bus_err_q;

  assign bus.m_data_addr   = addr_q;
  assign bus.m_data_wdata  = wdata_q;
  assign bus.m_data_byteen = byteen_q;
  assign bus.m_data_rd     = rd_q;
  assign bus.m_inst_addr   = pc_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64: cycles in ACCESS without m_data_ack before the access aborts as a bus error.
REQ-002 Parameter DATA_LIMIT, default 32'h0000_3000: first illegal data byte address; legal range is 0 .. DATA_LIMIT-1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  M-stage memory operation present.
REQ-006 req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store source (rt value).
REQ-009 req_pc  in  32  PC of the requesting instruction.
REQ-010 busy  out  1  pipeline stall request.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  extended load result, valid while done=1.
REQ-013 addr_err  out  1  misaligned or out-of-range address, valid while done=1.
REQ-014 bus_err  out  1  ack timeout, valid while done=1.
REQ-015 m_data_addr  out  32  bus address, word-aligned (low two bits forced to 0).
REQ-016 m_data_wdata  out  32  bus write data.
REQ-017 m_data_byteen  out  4  store byte lanes; 0 for loads and when idle.
REQ-018 m_data_rd  out  1  load strobe.
REQ-019 m_inst_addr  out  32  PC of the in-flight access.
REQ-020 m_data_ack  in  1  responder acknowledge; read data valid in the same cycle.
REQ-021 m_data_rdata  in  32  responder read word.

Function
REQ-022 FSM states: IDLE, ACCESS, RESP, ERR.
REQ-023 Requests are accepted only in IDLE; req_valid sampled in other states is ignored.
REQ-024 IDLE with req_valid: misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0) or req_addr>=DATA_LIMIT -> ERR, with no bus activity.
REQ-025 IDLE with a legal req_valid -> ACCESS; op, address, byte lanes, write data and PC are registered on entry.
REQ-026 Bus outputs come only from registers and stay stable for the whole ACCESS state.
REQ-027 Byte lanes: SW 1111; SH 1100 if addr[1] else 0011; SB 0001 shifted left by addr[1:0].
REQ-028 Write data: SW word; SH {2{wdata[15:0]}}; SB {4{wdata[7:0]}}.
REQ-029 Loads drive m_data_rd=1 and byteen=0; stores drive m_data_rd=0.
REQ-030 ACCESS with m_data_ack -> RESP; on loads, m_data_rdata is captured, lane-selected by addr[1:0] and extended (LH/LB sign-extend, LHU/LBU zero-extend) into rdata.
REQ-031 An ack timeout counter clears on entry to ACCESS; when it reaches ACK_TIMEOUT without ack -> ERR with bus_err=1.
REQ-032 ACCESS -> RESP and ACCESS -> ERR both drop all bus strobes in the following cycle.
REQ-033 RESP: done=1 and rdata valid (0 for stores) for one cycle, then -> IDLE.
REQ-034 ERR: done=1 for one cycle with exactly one of addr_err/bus_err set and rdata=0, then -> IDLE.
REQ-035 busy = req_valid & ~done (combinational); minimum latency from acceptance to done is 2 cycles with ack in the first ACCESS cycle.
REQ-036 An ack arriving in IDLE, RESP or ERR is ignored.

Reset
REQ-037 Asserting reset at any time, including mid-ACCESS, forces IDLE and clears all registers within the same cycle (asynchronous).
REQ-038 Reset values of all outputs: busy follows REQ-035; every other output, including bus strobes, is 0.

Structure
REQ-039 A shared package holds the req_op encodings, the FSM state enum and the DATA_LIMIT default.
REQ-040 One sub-module, load_extend: combinational lane select and extension, with inputs word, addr[1:0] and op.

Verification
REQ-041 SB addr 0x0000_0013, wdata 0xAABBCCDD, ack after 3 cycles -> byteen 1000, wdata 0xDDDDDDDD, addr 0x10, done on the 5th cycle after acceptance.
REQ-042 LH addr 0x22, rdata word 0x8001_7FFF, ack immediately -> rdata 0xFFFF8001; LHU on the same word -> 0x00008001.
REQ-043 LW addr 0x0000_0006 -> ERR, addr_err=1, byteen and rd stay 0 throughout; same for SW addr 0x3000.
REQ-044 SW with ack never asserted, ACK_TIMEOUT=64 -> bus_err pulse 65 cycles after acceptance, strobes 0 afterwards.
REQ-045 Reset asserted during the 2nd ACCESS cycle of an SH -> byteen immediately 0, state IDLE, a following LB completes normally.
